reg_bus_rr_arbiter: RTL and testbench
=====================================

Name: reg_bus_rr_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the single-phase register bus: address, write, wdata and wstrb are presented with valid; completion occurs on valid and ready.
- Grants masters round-robin and holds the grant until the slave completes.
- Adds an optional per-transaction timeout that terminates hung transactions with an error response.
- Sits between multiple configuration masters (debug module, core peripheral port, DMA) and one shared register bus segment.

Parameters:
- N_MST, 4, number of upstream masters (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT, 0, maximum downstream cycles per transaction; 0 disables the timeout.
- IDX_W, $clog2(N_MST), width of the grant index (localparam).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- mst_addr_i  in  N_MST*ADDR_WIDTH  per-master address; master m in slice m.
- mst_write_i  in  N_MST  per-master write flag (1=write).
- mst_wdata_i  in  N_MST*DATA_WIDTH  per-master write data.
- mst_wstrb_i  in  N_MST*DATA_WIDTH/8  per-master byte strobe.
- mst_valid_i  in  N_MST  per-master request valid.
- mst_rdata_o  out  N_MST*DATA_WIDTH  per-master read data.
- mst_error_o  out  N_MST  per-master error.
- mst_ready_o  out  N_MST  per-master completion.
- slv_addr_o  out  ADDR_WIDTH  downstream address.
- slv_write_o  out  1  downstream write flag.
- slv_wdata_o  out  DATA_WIDTH  downstream write data.
- slv_wstrb_o  out  DATA_WIDTH/8  downstream strobe.
- slv_valid_o  out  1  downstream valid.
- slv_rdata_i  in  DATA_WIDTH  downstream read data.
- slv_error_i  in  1  downstream error.
- slv_ready_i  in  1  downstream completion.
- busy_o  out  1  a transaction is granted.
- gnt_idx_o  out  IDX_W  index of the current or last granted master.
- timeout_o  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- FSM states IDLE and BUSY. Reset state: IDLE, priority pointer ptr=0, gnt_idx=0, cnt=0.
- Reset output values:
  - slv_valid_o=0, busy_o=0, timeout_o=0, gnt_idx_o=0.
  - All mst_ready_o=0, mst_error_o=0 and mst_rdata_o=0.
  - slv_addr/wdata/wstrb/write reflect master 0 (don't-care while valid=0).
- Arbitration in IDLE:
  - If any mst_valid_i is set, choose the first set bit searching from ptr, ptr+1, ... wrapping modulo N_MST.
  - Register the choice into gnt_idx, clear cnt, go to BUSY.
  - If no mst_valid_i is set, stay in IDLE.
- Latency:
  - Downstream valid rises the cycle after a request is seen in IDLE.
  - A 1-cycle bubble follows every completion, so peak throughput is 1 transaction per 2 cycles.
- BUSY:
  - slv_valid_o=1; request fields are muxed combinationally from master gnt_idx.
  - Masters hold their fields stable while valid is high.
- Response routing:
  - mst_ready_o[gnt]=slv_ready_i, mst_error_o[gnt]=slv_error_i, mst_rdata_o[gnt]=slv_rdata_i.
  - Non-granted masters see ready=0, error=0, rdata=0.
- Completion:
  - Occurs when slv_ready_i=1 in BUSY.
  - Next state IDLE; ptr <= (gnt_idx+1) mod N_MST, so the winner gets the lowest priority next round.
- Timeout (TIMEOUT>0):
  - cnt increments each BUSY cycle with slv_ready_i=0.
  - If cnt==TIMEOUT-1 and slv_ready_i=0, abort in that cycle: mst_ready_o[gnt]=1, mst_error_o[gnt]=1, mst_rdata_o[gnt]=0, timeout_o=1.
  - Next state IDLE and ptr advances as for a normal completion.
  - slv_valid_o drops after an abort. This deliberately breaks downstream valid-hold; slaves behind this block must tolerate it.
  - A slave ready in the abort cycle wins: normal completion, no timeout.
  - cnt width is $clog2(TIMEOUT+1).
- TIMEOUT=0: cnt is unused and timeout_o is tied to 0.
- Simultaneous events:
  - A master that deasserts valid while granted is a protocol violation; no specific recovery is defined.
  - A new request from the just-completed master in the completion cycle is arbitrated normally in the following IDLE cycle.
- Reset mid-transaction:
  - Asynchronous return to IDLE; all outputs go to their reset values immediately.
  - The in-flight transaction is lost and the master sees no ready.
- busy_o=1 exactly while in BUSY. gnt_idx_o holds its value in IDLE.

Test Plan:
- Single master: N_MST=4, master 2 writes addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; slave ready 2 cycles after slv_valid. Required: slv_valid rises 1 cycle after mst_valid[2], fields match, mst_ready[2]=1 in the slave-ready cycle, ptr becomes 3.
- Fairness: all 4 masters request continuously with slave ready immediate. Required: grant order 0,1,2,3,0, each completion 2 cycles apart, no master starved.
- Read data/error: master 1 reads, slave returns rdata 0x12345678 with error=1. Required: mst_rdata[1]=0x12345678, mst_error[1]=1; other masters see ready=0 and rdata=0.
- Timeout: TIMEOUT=8, slave never ready. Required: on the 8th BUSY cycle mst_ready=1, mst_error=1, rdata=0, timeout_o pulses for 1 cycle, slv_valid=0 on the next cycle. Also: with ready in the 8th cycle, a normal completion with timeout_o=0.
- Wrap-around: ptr=3, masters 0 and 3 request. Required: 3 is granted, then 0.
- Reset mid-operation: assert rst_i during BUSY. Required: slv_valid_o, busy_o and mst_ready_o go to 0 the same cycle; after release, a pending request from master 0 is granted first.

Source files
------------

// File: rtl/reg_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one single-phase register bus segment
//   between N_MST configuration masters (debug module, core peripheral port,
//   DMA, ...). A request is the set {addr, write, wdata, wstrb} qualified by
//   valid; a transaction completes in the cycle where valid and ready are both
//   high. The winning master keeps the grant until the slave completes. With
//   TIMEOUT > 0, a transaction that runs for TIMEOUT downstream cycles without
//   a ready is aborted and answered with an error.
//
//   Throughput: the grant is registered in IDLE and the downstream request is
//   driven from BUSY. So there is one idle bubble after every completion, and
//   the peak rate is one transaction every two cycles.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   mst_addr_i           per-master address, master m in slice m
//   mst_write_i          per-master write flag (1 = write)
//   mst_wdata_i          per-master write data
//   mst_wstrb_i          per-master byte strobes
//   mst_valid_i          per-master request valid
//   mst_rdata_o          per-master read data (zero for non-granted masters)
//   mst_error_o          per-master error response
//   mst_ready_o          per-master completion
//   slv_addr_o .. slv_valid_o   downstream request, muxed from the granted master
//   slv_rdata_i, slv_error_i, slv_ready_i   downstream response
//   busy_o               high while a transaction is granted
//   gnt_idx_o            index of the current or last granted master
//   timeout_o            one-cycle pulse when a transaction is aborted
// -----------------------------------------------------------------------------
module reg_bus_rr_arbiter #(
    parameter  int N_MST      = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 0,
    localparam int IDX_W      = $clog2(N_MST),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic [N_MST*ADDR_WIDTH-1:0]   mst_addr_i,
    input  logic [N_MST-1:0]              mst_write_i,
    input  logic [N_MST*DATA_WIDTH-1:0]   mst_wdata_i,
    input  logic [N_MST*STRB_W-1:0]       mst_wstrb_i,
    input  logic [N_MST-1:0]              mst_valid_i,
    output logic [N_MST*DATA_WIDTH-1:0]   mst_rdata_o,
    output logic [N_MST-1:0]              mst_error_o,
    output logic [N_MST-1:0]              mst_ready_o,

    output logic [ADDR_WIDTH-1:0]         slv_addr_o,
    output logic                          slv_write_o,
    output logic [DATA_WIDTH-1:0]         slv_wdata_o,
    output logic [STRB_W-1:0]             slv_wstrb_o,
    output logic                          slv_valid_o,
    input  logic [DATA_WIDTH-1:0]         slv_rdata_i,
    input  logic                          slv_error_i,
    input  logic                          slv_ready_i,

    output logic                          busy_o,
    output logic [IDX_W-1:0]              gnt_idx_o,
    output logic                          timeout_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_gnt;
    logic [IDX_W-1:0]       w_pick;
    logic [IDX_W-1:0]       w_ofs;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [IDX_W:0]         w_sum;
    logic [2*N_MST-1:0]     w_valid_dbl;
    logic [N_MST-1:0]       w_valid_rot;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_abort;
    logic                   w_done;

    // ------------------------------------------------------------------
    // Round-robin search.
    // The valid vector is rotated so that bit 0 is the master at r_ptr.
    // The first set bit gives an offset from r_ptr, and that offset is
    // added back to r_ptr modulo N_MST. Concatenating the vector with
    // itself makes the rotation a plain part-select, and it also works
    // when N_MST is not a power of two.
    // ------------------------------------------------------------------
    assign w_valid_dbl = {mst_valid_i, mst_valid_i};
    assign w_valid_rot = w_valid_dbl[r_ptr +: N_MST];

    always_comb begin
        w_any = |w_valid_rot;
        w_ofs = '0;
        for (int i = N_MST - 1; i >= 0; i--) begin
            if (w_valid_rot[i]) begin
                w_ofs = IDX_W'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_ofs};
        if (w_sum >= (IDX_W + 1)'(N_MST)) begin
            w_pick = IDX_W'(w_sum - (IDX_W + 1)'(N_MST));
        end else begin
            w_pick = w_sum[IDX_W-1:0];
        end
    end

    // The winner drops to the lowest priority for the next round.
    assign w_ptr_next = (r_gnt == IDX_W'(N_MST - 1)) ? '0 : r_gnt + IDX_W'(1);

    assign w_grant = (r_state == IDLE) && w_any;

    // A transaction ends either on slave ready or on a timeout abort.
    // A ready in the abort cycle wins, because w_abort requires !slv_ready_i.
    assign w_done  = (r_state == BUSY) && (slv_ready_i || w_abort);

    // ------------------------------------------------------------------
    // Transaction timeout.
    // cnt counts the BUSY cycles that had no ready. The abort fires in the
    // cycle where cnt reaches TIMEOUT-1, which is the TIMEOUT-th BUSY cycle.
    // cnt can reach TIMEOUT after an abort, so it is sized for TIMEOUT+1
    // values. It is cleared when the next grant is issued.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (w_grant) begin
                    r_cnt <= '0;
                end else if ((r_state == BUSY) && !slv_ready_i) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_abort = (r_state == BUSY) && !slv_ready_i &&
                             (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_abort = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant index and priority pointer.
    // gnt_idx keeps its value through IDLE, so the slave mux points at the
    // last winner (or at master 0 after reset) while valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_pick;
            end
            if (w_done) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs and response routing.
    // Only the granted master sees the slave response, and only in BUSY.
    // The other masters see zeros. On an abort, the granted master gets
    // ready plus error, with zero read data.
    // ------------------------------------------------------------------
    always_comb begin
        slv_valid_o = (r_state == BUSY);
        busy_o      = (r_state == BUSY);
        timeout_o   = w_abort;
        mst_ready_o = '0;
        mst_error_o = '0;
        mst_rdata_o = '0;
        if (r_state == BUSY) begin
            mst_ready_o[r_gnt] = slv_ready_i | w_abort;
            mst_error_o[r_gnt] = slv_error_i | w_abort;
            if (!w_abort) begin
                mst_rdata_o[r_gnt*DATA_WIDTH +: DATA_WIDTH] = slv_rdata_i;
            end
        end
    end

    // Downstream request fields come straight from the granted master.
    assign slv_addr_o  = mst_addr_i [r_gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign slv_write_o = mst_write_i[r_gnt];
    assign slv_wdata_o = mst_wdata_i[r_gnt*DATA_WIDTH +: DATA_WIDTH];
    assign slv_wstrb_o = mst_wstrb_i[r_gnt*STRB_W +: STRB_W];
    assign gnt_idx_o   = r_gnt;

endmodule

// File: tb/tb_reg_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_rr_arbiter
//
// Directed bench for reg_bus_rr_arbiter with four masters and TIMEOUT = 8.
// Each request that is driven pushes the transaction the slave side should
// see next onto a scoreboard queue. Every new downstream grant pops the queue
// and compares the front entry against the muxed slave fields.
// -----------------------------------------------------------------------------
module tb_reg_bus_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NM*AW-1:0]   mstAddr;
    logic [NM-1:0]      mstWrite;
    logic [NM*DW-1:0]   mstWdata;
    logic [NM*SW-1:0]   mstWstrb;
    logic [NM-1:0]      mstValid;
    logic [NM*DW-1:0]   mstRdata;
    logic [NM-1:0]      mstError;
    logic [NM-1:0]      mstReady;
    logic [AW-1:0]      slvAddr;
    logic               slvWrite;
    logic [DW-1:0]      slvWdata;
    logic [SW-1:0]      slvWstrb;
    logic               slvValid;
    logic [DW-1:0]      slvRdata;
    logic               slvError;
    logic               slvReady;
    logic               busy;
    logic [1:0]         gntIdx;
    logic               timeoutPulse;

    always #5 clk = ~clk;

    reg_bus_rr_arbiter #(
        .N_MST      (NM),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mst_addr_i  (mstAddr),
        .mst_write_i (mstWrite),
        .mst_wdata_i (mstWdata),
        .mst_wstrb_i (mstWstrb),
        .mst_valid_i (mstValid),
        .mst_rdata_o (mstRdata),
        .mst_error_o (mstError),
        .mst_ready_o (mstReady),
        .slv_addr_o  (slvAddr),
        .slv_write_o (slvWrite),
        .slv_wdata_o (slvWdata),
        .slv_wstrb_o (slvWstrb),
        .slv_valid_o (slvValid),
        .slv_rdata_i (slvRdata),
        .slv_error_i (slvError),
        .slv_ready_i (slvReady),
        .busy_o      (busy),
        .gnt_idx_o   (gntIdx),
        .timeout_o   (timeoutPulse)
    );

    typedef struct {
        logic [1:0]    idx;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wd;
        logic [SW-1:0] st;
    } txn_t;

    txn_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request on master m and record the grant that should follow.
    task automatic applyStimulus(input logic [1:0] m, input logic [AW-1:0] a, input logic w,
                                 input logic [DW-1:0] d, input logic [SW-1:0] s);
        txn_t t;
        mstAddr[m*AW +: AW]  = a;
        mstWrite[m]          = w;
        mstWdata[m*DW +: DW] = d;
        mstWstrb[m*SW +: SW] = s;
        mstValid[m]          = 1'b1;
        t.idx  = m;
        t.addr = a;
        t.wr   = w;
        t.wd   = d;
        t.st   = s;
        sbQ.push_back(t);
    endtask

    // Record another expected grant of master m with the fields it is already driving.
    task automatic pushExp(input logic [1:0] m);
        txn_t t;
        t.idx  = m;
        t.addr = mstAddr[m*AW +: AW];
        t.wr   = mstWrite[m];
        t.wd   = mstWdata[m*DW +: DW];
        t.st   = mstWstrb[m*SW +: SW];
        sbQ.push_back(t);
    endtask

    // Pop the next expected grant and compare it with the downstream side.
    task automatic checkGrant(output logic [1:0] gi);
        txn_t e;
        gi = 2'd0;
        checks++;
        assert (sbQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL sb_empty observed=%0d expected=nonzero", sbQ.size());
        end
        if (sbQ.size() > 0) begin
            e  = sbQ.pop_front();
            gi = e.idx;
            checkOutput("gnt_idx",   gntIdx,   e.idx);
            checkOutput("slv_valid", slvValid, 1'b1);
            checkOutput("busy",      busy,     1'b1);
            checkOutput("slv_addr",  slvAddr,  e.addr);
            checkOutput("slv_write", slvWrite, e.wr);
            checkOutput("slv_wdata", slvWdata, e.wd);
            checkOutput("slv_wstrb", slvWstrb, e.st);
        end
    endtask

    // Expected response vectors: only master m sees the response.
    task automatic checkResp(input logic [1:0] m, input logic rdy, input logic err, input logic [DW-1:0] rd);
        logic [NM-1:0]    rdyV;
        logic [NM-1:0]    errV;
        logic [NM*DW-1:0] rdV;
        rdyV = '0;
        errV = '0;
        rdV  = '0;
        rdyV[m] = rdy;
        errV[m] = err;
        rdV[m*DW +: DW] = rd;
        checkOutput("mst_ready", mstReady, rdyV);
        checkOutput("mst_error", mstError, errV);
        checkOutput("mst_rdata", mstRdata, rdV);
    endtask

    initial begin
        logic [1:0] gi;

        rst      = 1'b1;
        mstAddr  = '0;
        mstWrite = '0;
        mstWdata = '0;
        mstWstrb = '0;
        mstValid = '0;
        mstAddr[0 +: AW] = 32'h0000_0BEE;
        slvRdata = 32'hAAAA_AAAA;
        slvError = 1'b1;
        slvReady = 1'b1;

        // Reset values, with a live-looking slave response that must be ignored.
        #12;
        checkOutput("rst_slv_valid", slvValid,     1'b0);
        checkOutput("rst_busy",      busy,         1'b0);
        checkOutput("rst_timeout",   timeoutPulse, 1'b0);
        checkOutput("rst_gnt",       gntIdx,       2'd0);
        checkOutput("rst_ready",     mstReady,     4'b0);
        checkOutput("rst_error",     mstError,     4'b0);
        checkOutput("rst_rdata",     mstRdata,     128'd0);
        checkOutput("rst_slv_addr",  slvAddr,      32'h0000_0BEE);

        @(posedge clk);
        #1;
        rst      = 1'b0;
        slvRdata = '0;
        slvError = 1'b0;
        slvReady = 1'b0;

        // Single master write: valid rises one cycle later, ready two cycles after that.
        applyStimulus(2'd2, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        #1;
        checkOutput("lat_valid_low", slvValid, 1'b0);
        step();
        checkGrant(gi);
        checkResp(2'd2, 1'b0, 1'b0, 32'h0);
        step();
        step();
        slvReady = 1'b1;
        #1;
        checkResp(2'd2, 1'b1, 1'b0, 32'h0);
        step();
        slvReady    = 1'b0;
        mstValid[2] = 1'b0;
        #1;
        checkOutput("bubble_busy",  busy,     1'b0);
        checkOutput("bubble_valid", slvValid, 1'b0);

        // Wrap-around: the pointer now sits at 3, so master 3 beats master 0.
        applyStimulus(2'd3, 32'h300, 1'b1, 32'h3333_0003, 4'h5);
        applyStimulus(2'd0, 32'h100, 1'b0, 32'h0,         4'h0);
        step();
        checkGrant(gi);
        slvRdata = 32'h0BAD_F00D;
        slvReady = 1'b1;
        #1;
        checkResp(2'd3, 1'b1, 1'b0, 32'h0BAD_F00D);
        step();
        mstValid[3] = 1'b0;
        slvReady    = 1'b0;
        #1;
        checkOutput("wrap_bubble", busy, 1'b0);
        step();
        checkGrant(gi);
        slvRdata = 32'h0000_C0DE;
        slvReady = 1'b1;
        #1;
        checkResp(2'd0, 1'b1, 1'b0, 32'h0000_C0DE);
        step();
        mstValid[0] = 1'b0;
        slvReady    = 1'b0;

        // Read with an error response, routed only to master 1.
        applyStimulus(2'd1, 32'h20, 1'b0, 32'h0, 4'h0);
        step();
        checkGrant(gi);
        slvRdata = 32'h1234_5678;
        slvError = 1'b1;
        slvReady = 1'b1;
        #1;
        checkResp(2'd1, 1'b1, 1'b1, 32'h1234_5678);
        step();
        mstValid[1] = 1'b0;
        slvReady    = 1'b0;
        slvError    = 1'b0;

        // Timeout: the slave never answers, so the 8th BUSY cycle aborts.
        slvRdata = 32'hFFFF_FFFF;
        applyStimulus(2'd3, 32'h30, 1'b1, 32'hCAFE_F00D, 4'h3);
        step();
        checkGrant(gi);
        for (int k = 1; k < TO; k++) begin
            checkOutput("to_wait_ready", mstReady,     4'b0);
            checkOutput("to_wait_pulse", timeoutPulse, 1'b0);
            step();
        end
        checkResp(2'd3, 1'b1, 1'b1, 32'h0);
        checkOutput("to_pulse", timeoutPulse, 1'b1);
        step();
        mstValid[3] = 1'b0;
        #1;
        checkOutput("to_valid_drop", slvValid,     1'b0);
        checkOutput("to_pulse_end",  timeoutPulse, 1'b0);

        // A ready in the 8th cycle is a normal completion.
        applyStimulus(2'd0, 32'h40, 1'b0, 32'h0, 4'h0);
        step();
        checkGrant(gi);
        repeat (TO - 1) step();
        slvRdata = 32'h55AA_55AA;
        slvReady = 1'b1;
        #1;
        checkResp(2'd0, 1'b1, 1'b0, 32'h55AA_55AA);
        checkOutput("late_ready_pulse", timeoutPulse, 1'b0);
        step();
        mstValid[0] = 1'b0;
        slvReady    = 1'b0;
        #1;
        checkOutput("late_ready_idle", busy, 1'b0);

        // Reset in the middle of a BUSY cycle that is about to complete.
        applyStimulus(2'd2, 32'h50, 1'b1, 32'h1111_2222, 4'hC);
        step();
        checkGrant(gi);
        slvRdata = 32'h0;
        slvReady = 1'b1;
        #1;
        checkOutput("pre_rst_ready", mstReady, 4'b0100);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", slvValid, 1'b0);
        checkOutput("mid_rst_busy",  busy,     1'b0);
        checkOutput("mid_rst_ready", mstReady, 4'b0);
        checkOutput("mid_rst_gnt",   gntIdx,   2'd0);
        mstValid[2] = 1'b0;

        // After the reset, all masters request with an always-ready slave:
        // grants go 0,1,2,3,0 with one idle bubble between completions.
        applyStimulus(2'd0, 32'hA0, 1'b1, 32'hA000_0000, 4'h1);
        applyStimulus(2'd1, 32'hA4, 1'b0, 32'hA111_1111, 4'h2);
        applyStimulus(2'd2, 32'hA8, 1'b1, 32'hA222_2222, 4'h4);
        applyStimulus(2'd3, 32'hAC, 1'b1, 32'hA333_3333, 4'h8);
        pushExp(2'd0);
        step();
        rst = 1'b0;
        step();
        for (int n = 0; n < 5; n++) begin
            checkGrant(gi);
            checkResp(gi, 1'b1, 1'b0, 32'h0);
            step();
            checkOutput("fair_bubble", busy, 1'b0);
            step();
        end
        mstValid = '0;
        step();
        step();
        slvReady = 1'b0;
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
